// File: rtl/flash_spi_pkg.sv
// Shared definitions for the SPI NOR program-memory bridge.
//   FLASH_AW     : width of the core-side fetch address
//   SPI_AW       : width of the flash byte address sent on the bus
//   SPI_READ_CMD : standard READ opcode
//   state_e      : sequencing states of the bridge FSM
package flash_spi_pkg;

    localparam int         FLASH_AW     = 12;
    localparam int         SPI_AW       = 24;
    localparam logic [7:0] SPI_READ_CMD = 8'h03;

    typedef enum logic [2:0] {
        GAP   = 3'd0,
        CMD   = 3'd1,
        ADDR  = 3'd2,
        DATA  = 3'd3,
        READY = 3'd4
    } state_e;

endpackage

// File: rtl/spi_byte_shifter.sv
// Mode-0 SPI byte engine: generates SCK and moves one byte out on MOSI and
// one byte in from MISO, MSB first.
//   clk, arst_n : clock, asynchronous active-low reset
//   start       : load tx_byte_i and begin a byte (also legal in the done cycle)
//   tx_byte_i   : byte to transmit
//   miso_i      : serial input, sampled on SCK rising edge
//   done        : one-cycle pulse in the last cycle of a byte
//   rx_byte_o   : received byte, complete while done is high
//   sck_o       : SPI clock, idles low
//   mosi_o      : serial output, 0 while idle
//
// Handshake: start is a single-cycle request accepted unconditionally when
// the engine is idle or in its done cycle; done pulses exactly once per
// accepted start, 16*CLK_DIV cycles after it, and rx_byte_o is valid with it.
module spi_byte_shifter #(
    parameter int CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       arst_n,
    input  logic       start,
    input  logic [7:0] tx_byte_i,
    input  logic       miso_i,
    output logic       done,
    output logic [7:0] rx_byte_o,
    output logic       sck_o,
    output logic       mosi_o
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic             busy_q, busy_d;
    logic             sck_q, sck_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       tx_q, tx_d;
    logic [7:0]       rx_q, rx_d;
    logic             phase_end;

    always_comb begin
        phase_end = (div_q == DIV_LAST);
        done      = busy_q && sck_q && phase_end && (bit_q == 3'd7);
        busy_d    = busy_q;
        sck_d     = sck_q;
        div_d     = div_q;
        bit_d     = bit_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        if (start) begin
            busy_d = 1'b1;
            sck_d  = 1'b0;
            div_d  = '0;
            bit_d  = 3'd0;
            tx_d   = tx_byte_i;
        end else if (busy_q) begin
            if (phase_end) begin
                div_d = '0;
                if (!sck_q) begin
                    // Rising edge: the flash drove this bit on the previous fall.
                    sck_d = 1'b1;
                    rx_d  = {rx_q[6:0], miso_i};
                end else begin
                    // Falling edge: advance MOSI while SCK is low.
                    sck_d = 1'b0;
                    if (bit_q == 3'd7) begin
                        busy_d = 1'b0;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = {tx_q[6:0], 1'b0};
                    end
                end
            end else begin
                div_d = div_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            busy_q <= 1'b0;
            sck_q  <= 1'b0;
            div_q  <= '0;
            bit_q  <= 3'd0;
            tx_q   <= 8'h00;
            rx_q   <= 8'h00;
        end else begin
            busy_q <= busy_d;
            sck_q  <= sck_d;
            div_q  <= div_d;
            bit_q  <= bit_d;
            tx_q   <= tx_d;
            rx_q   <= rx_d;
        end
    end

    assign rx_byte_o = rx_q;
    assign sck_o     = sck_q;
    assign mosi_o    = busy_q & tx_q[7];

endmodule

// File: rtl/flash_spi_bridge.sv
// Serves the core's 12-bit program-fetch port from an external SPI NOR flash
// using READ (0x03) in mode 0, streaming consecutive addresses without
// reissuing the command.
//   clk, arst_n  : clock, asynchronous active-low reset
//   flash_addr   : requested byte address (may change any cycle)
//   flash_data   : fetched byte, updated only when a data byte completes
//   flash_ready  : flash_data is valid for the present flash_addr
//   spi_sck      : SPI clock (idle low)
//   spi_cs_n     : chip select, active low
//   spi_mosi     : command/address bits, MSB first
//   spi_miso     : data from flash, sampled directly on SCK rise
//   dbg_state    : current FSM state for observation
module flash_spi_bridge
    import flash_spi_pkg::*;
#(
    parameter int                CLK_DIV   = 2,
    parameter int                CS_GAP    = 2,
    parameter logic [SPI_AW-1:0] BASE_ADDR = 24'h000000
) (
    input  logic                clk,
    input  logic                arst_n,
    input  logic [FLASH_AW-1:0] flash_addr,
    output logic [7:0]          flash_data,
    output logic                flash_ready,
    output logic                spi_sck,
    output logic                spi_cs_n,
    output logic                spi_mosi,
    input  logic                spi_miso,
    output state_e              dbg_state
);

    localparam int GAP_W = (CS_GAP > 0) ? $clog2(CS_GAP + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP);

    state_e              state_q, state_d;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
    logic [1:0]          byte_cnt_q, byte_cnt_d;
    logic [FLASH_AW-1:0] cur_addr_q, cur_addr_d;
    logic [7:0]          flash_data_q, flash_data_d;

    logic                sh_start;
    logic [7:0]          sh_tx;
    logic                sh_done;
    logic [7:0]          sh_rx;
    logic [SPI_AW-1:0]   spi_addr;

    // Flash address wraps modulo 2^24.
    assign spi_addr = BASE_ADDR + {{(SPI_AW-FLASH_AW){1'b0}}, cur_addr_q};

    spi_byte_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk       (clk),
        .arst_n    (arst_n),
        .start     (sh_start),
        .tx_byte_i (sh_tx),
        .miso_i    (spi_miso),
        .done      (sh_done),
        .rx_byte_o (sh_rx),
        .sck_o     (spi_sck),
        .mosi_o    (spi_mosi)
    );

    // Each new byte is started on the edge that enters its state, so bytes
    // run back to back with no idle cycle between them.
    always_comb begin
        state_d      = state_q;
        gap_cnt_d    = gap_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        cur_addr_d   = cur_addr_q;
        flash_data_d = flash_data_q;
        sh_start     = 1'b0;
        sh_tx        = 8'h00;
        unique case (state_q)
            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d  = '0;
                    cur_addr_d = flash_addr;
                    sh_start   = 1'b1;
                    sh_tx      = SPI_READ_CMD;
                    state_d    = CMD;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            CMD: begin
                if (sh_done) begin
                    byte_cnt_d = 2'd0;
                    sh_start   = 1'b1;
                    sh_tx      = spi_addr[23:16];
                    state_d    = ADDR;
                end
            end
            ADDR: begin
                if (sh_done) begin
                    sh_start = 1'b1;
                    if (byte_cnt_q == 2'd2) begin
                        sh_tx   = 8'h00;
                        state_d = DATA;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        sh_tx      = (byte_cnt_q == 2'd0) ? spi_addr[15:8] : spi_addr[7:0];
                    end
                end
            end
            DATA: begin
                if (sh_done) begin
                    flash_data_d = sh_rx;
                    state_d      = READY;
                end
            end
            READY: begin
                if (flash_addr != cur_addr_q) begin
                    // The flash auto-increments, so only the next address can
                    // be streamed; 0xFFF -> 0x000 is not contiguous in flash.
                    if ((flash_addr == cur_addr_q + 12'd1) && (cur_addr_q != 12'hFFF)) begin
                        cur_addr_d = cur_addr_q + 12'd1;
                        sh_start   = 1'b1;
                        state_d    = DATA;
                    end else begin
                        state_d = GAP;
                    end
                end
            end
            default: state_d = GAP;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q      <= GAP;
            gap_cnt_q    <= '0;
            byte_cnt_q   <= 2'd0;
            cur_addr_q   <= '0;
            flash_data_q <= 8'h00;
        end else begin
            state_q      <= state_d;
            gap_cnt_q    <= gap_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            cur_addr_q   <= cur_addr_d;
            flash_data_q <= flash_data_d;
        end
    end

    // CS follows the registered state, so reset raises it asynchronously.
    assign spi_cs_n    = (state_q == GAP);
    assign flash_ready = (state_q == READY) && (flash_addr == cur_addr_q);
    assign flash_data  = flash_data_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_flash_spi_bridge.sv
module tb_flash_spi_bridge;
    import flash_spi_pkg::*;

    localparam int          CLK_DIV   = 2;
    localparam int          CS_GAP    = 2;
    localparam logic [23:0] BASE      = 24'hFFFF80;
    // First GAP cycle to ready: gap, 40 SPI bits, one latch cycle.
    localparam int          RESET_LAT = CS_GAP + 40 * 2 * CLK_DIV + 1;
    // From READY, one extra cycle is spent deciding to leave for GAP.
    localparam int          RAND_LAT  = RESET_LAT + 1;
    localparam int          SEQ_LAT   = 1 + 8 * 2 * CLK_DIV;
    localparam int          MAX_WAIT  = 600;

    // ---------------- clock / reset ----------------
    logic        clk;
    logic        arst_n;
    logic [11:0] flash_addr;
    logic [7:0]  flash_data;
    logic        flash_ready;
    logic        spi_sck;
    logic        spi_cs_n;
    logic        spi_mosi;
    logic        spi_miso;
    state_e      dbg_state;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    flash_spi_bridge #(
        .CLK_DIV   (CLK_DIV),
        .CS_GAP    (CS_GAP),
        .BASE_ADDR (BASE)
    ) dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .flash_addr  (flash_addr),
        .flash_data  (flash_data),
        .flash_ready (flash_ready),
        .spi_sck     (spi_sck),
        .spi_cs_n    (spi_cs_n),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .dbg_state   (dbg_state)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- flash content and SPI flash model ----------------
    function automatic logic [7:0] flash_byte(input logic [23:0] fa);
        logic [7:0] h;
        if (fa == BASE) return 8'hA5;
        h = (fa[7:0] * 8'd29) + (fa[15:8] * 8'd7) + fa[23:16];
        return h ^ 8'h5A;
    endfunction

    function automatic logic [7:0] exp_byte(input logic [11:0] a);
        logic [23:0] fa;
        fa = BASE + {12'h000, a};
        return flash_byte(fa);
    endfunction

    logic [31:0] exp_q[$];   // expected {cmd, addr24} per CS-low transaction
    int          exp_txn = 0;
    int          txn_cnt = 0;
    int          bit_n   = 0;
    logic [31:0] hdr;
    logic [23:0] rd_addr;
    logic [7:0]  out_sh;

    always @(negedge spi_cs_n) begin
        bit_n = 0;
        hdr   = '0;
        txn_cnt++;
    end

    always @(posedge spi_sck) begin
        if (spi_cs_n === 1'b0) begin
            if (bit_n < 32) begin
                hdr = {hdr[30:0], spi_mosi};
                if (bit_n == 31) begin
                    rd_addr = hdr[23:0];
                    check_eq("hdr_pending", 32'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) check_eq("hdr", hdr, exp_q.pop_front());
                end
            end
            bit_n++;
        end
    end

    always @(negedge spi_sck) begin
        int k;
        if (spi_cs_n === 1'b0 && bit_n >= 32) begin
            k = (bit_n - 32) % 8;
            if (k == 0) begin
                out_sh  = flash_byte(rd_addr);
                rd_addr = rd_addr + 24'd1;
            end
            spi_miso = out_sh[7-k];
        end
    end

    int hi_run = 0;
    always @(negedge clk) begin
        if (spi_cs_n === 1'b1) begin
            hi_run++;
        end else if (spi_cs_n === 1'b0) begin
            if (hi_run > 0) check_eq("cs_gap_min", 32'(hi_run >= CS_GAP), 1);
            hi_run = 0;
        end
    end

    // ---------------- reference model of fetch behaviour ----------------
    bit          model_valid = 1'b0;
    logic [11:0] model_cur   = 12'h000;

    task automatic predict(input logic [11:0] a, output int lat);
        if (model_valid && a == model_cur) begin
            lat = 0;
        end else if (model_valid && model_cur != 12'hFFF && int'(a) == int'(model_cur) + 1) begin
            lat = SEQ_LAT;
        end else begin
            exp_q.push_back({SPI_READ_CMD, BASE + {12'h000, a}});
            exp_txn++;
            lat = RAND_LAT;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_ready(output int lat);
        lat = 0;
        while (flash_ready !== 1'b1 && lat < MAX_WAIT) begin
            @(negedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic fetch(input logic [11:0] a);
        int exp_lat;
        int lat;
        @(negedge clk);
        predict(a, exp_lat);
        flash_addr = a;
        #1;
        if (exp_lat != 0) check_eq("ready_drop", flash_ready, 0);
        wait_ready(lat);
        check_eq("fetch_lat", lat, exp_lat);
        check_eq("fetch_data", flash_data, exp_byte(a));
        model_valid = 1'b1;
        model_cur   = a;
    endtask

    task automatic hold_check(input int n);
        repeat (n) @(negedge clk);
        #1;
        check_eq("hold_ready", flash_ready, 1);
        check_eq("hold_data", flash_data, exp_byte(model_cur));
    endtask

    // Address a must be a random fetch; b arrives k cycles later.
    task automatic fetch_interrupted(input logic [11:0] a, input logic [11:0] b, input int k);
        int lat_a;
        int lat_b;
        int lat;
        @(negedge clk);
        predict(a, lat_a);
        flash_addr = a;
        repeat (k) @(negedge clk);
        model_valid = 1'b1;
        model_cur   = a;
        predict(b, lat_b);
        flash_addr = b;
        #1;
        wait_ready(lat);
        check_eq("irq_lat", lat, lat_a - k + lat_b);
        check_eq("irq_data", flash_data, exp_byte(b));
        model_cur = b;
    endtask

    // arst_n must be low on entry; releases it and checks the first fetch.
    task automatic release_fetch(input logic [11:0] a);
        int lat;
        flash_addr = a;
        repeat (3) @(negedge clk);
        exp_q.push_back({SPI_READ_CMD, BASE + {12'h000, a}});
        exp_txn++;
        model_valid = 1'b0;
        arst_n = 1'b1;
        #1;
        wait_ready(lat);
        check_eq("reset_lat", lat, RESET_LAT);
        check_eq("reset_data", flash_data, exp_byte(a));
        model_valid = 1'b1;
        model_cur   = a;
    endtask

    task automatic reset_mid_data(input logic [11:0] a);
        int lat;
        int n;
        @(negedge clk);
        predict(a, lat);
        flash_addr = a;
        repeat (140) @(negedge clk);
        n = 0;
        while (spi_sck !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        check_eq("sck_high_pre_rst", spi_sck, 1);
        arst_n = 1'b0;
        #1;
        check_eq("arst_cs_n", spi_cs_n, 1);
        check_eq("arst_sck", spi_sck, 0);
        check_eq("arst_ready", flash_ready, 0);
        check_eq("arst_data", flash_data, 8'h00);
        check_eq("arst_mosi", spi_mosi, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int          kind;
        logic [11:0] nxt;
        arst_n     = 1'b0;
        flash_addr = 12'h000;
        spi_miso   = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_cs_n", spi_cs_n, 1);
        check_eq("rst_sck", spi_sck, 0);
        check_eq("rst_mosi", spi_mosi, 0);
        check_eq("rst_data", flash_data, 8'h00);
        check_eq("rst_ready", flash_ready, 0);
        check_eq("rst_state", dbg_state, GAP);

        release_fetch(12'h000);       // A5, first random fetch
        fetch(12'h001);               // streamed
        fetch(12'h002);
        hold_check(5);
        fetch(12'h100);               // jump, flash address wraps past 2^24
        fetch(12'hFFE);
        fetch(12'hFFF);
        fetch(12'h000);               // wrap is a random fetch
        fetch_interrupted(12'h234, 12'h235, 50);
        fetch_interrupted(12'h400, 12'h123, 60);
        fetch_interrupted(12'h500, 12'h500, 45);

        for (int i = 0; i < 24; i++) begin
            kind = $urandom_range(0, 3);
            case (kind)
                0: fetch(model_cur + 12'd1);
                1: begin
                    nxt = 12'($urandom_range(0, 4095));
                    fetch(nxt);
                end
                2: fetch(model_cur);
                default: hold_check($urandom_range(1, 6));
            endcase
        end

        reset_mid_data(model_cur + 12'h100);
        release_fetch(12'h07F);       // flash address 0xFFFFFF
        fetch(12'h080);               // streams across the 2^24 wrap
        fetch(12'h081);

        repeat (4) @(negedge clk);
        check_eq("hdr_q_empty", exp_q.size(), 0);
        check_eq("txn_count", txn_cnt, exp_txn);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/flash_spi_bridge.md
# flash_spi_bridge

Program-memory responder for the 8-bit microcontroller core: it serves the core's 12-bit `flash_addr` fetch port. For each requested address it returns the byte from an external SPI NOR flash on `flash_data` and signals validity on `flash_ready`. It issues standard READ (0x03) transactions in SPI mode 0. Consecutive addresses are streamed without reissuing the command, which keeps instruction fetch cheap.

## Interface
Parameters:
- `CLK_DIV`, default 2: SCK half-period in `clk` cycles. Minimum 1.
- `CS_GAP`, default 2: minimum `spi_cs_n` high time in `clk` cycles between transactions.
- `BASE_ADDR`, default 24'h000000: flash byte address that corresponds to `flash_addr` = 0.

Ports:
- `clk` (in, 1): single clock. All logic is rising-edge.
- `arst_n` (in, 1): asynchronous, active-low reset.
- `flash_addr` (in, 12): byte address requested by the core. It may change on any cycle.
- `flash_data` (out, 8): byte fetched for the current address.
- `flash_ready` (out, 1): high only while `flash_data` is valid for the present `flash_addr`.
- `spi_sck` (out, 1): SPI clock. Idles low (mode 0).
- `spi_cs_n` (out, 1): chip select, active low.
- `spi_mosi` (out, 1): command/address bits, MSB first.
- `spi_miso` (in, 1): data from the flash. It is sampled directly, with no synchroniser, because the flash is synchronous to SCK.

## Operation
- FSM states: `GAP`, `CMD`, `ADDR`, `DATA`, `READY`.
- `GAP`:
  - `spi_cs_n` = 1.
  - Count `CS_GAP` cycles.
  - Latch `cur_addr` ← `flash_addr`, then go to `CMD`.
- `CMD`: assert CS, shift 8'h03. Go to `ADDR`.
- `ADDR`: shift `BASE_ADDR + {12'h0, cur_addr}` as 24 bits (mod 2^24). Go to `DATA`.
- `DATA`: shift in 8 bits, MSB first, into `flash_data`. Go to `READY`.
- SPI bit timing: MOSI changes with SCK low; MISO is sampled on the SCK rising edge. Each bit lasts 2·`CLK_DIV` cycles. SCK returns low after the last bit of each byte.
- `READY` holds CS low and SCK low. It evaluates `flash_addr` every cycle:
  - Equal to `cur_addr`: stay.
  - Equal to `cur_addr+1`, and `cur_addr` ≠ 12'hFFF: set `cur_addr` ← `cur_addr+1` and go to `DATA`. This is a sequential fetch with no command or address phase.
  - Any other value, including the wrap from 12'hFFF to 12'h000: deassert CS and go to `GAP`.
- `flash_ready` = (state == `READY`) && (`flash_addr` == `cur_addr`). It is combinational on the address compare, so a stale byte is never marked valid for a new address.
- If `flash_addr` changes during `CMD`/`ADDR`/`DATA`, the transfer for the latched `cur_addr` completes. The `READY` rules then apply on the first `READY` cycle, so the result may be sequential or random.
- `flash_data` updates only when a byte completes. It holds its value in all other states.

## Timing
- Reset values: `spi_cs_n`=1, `spi_sck`=0, `spi_mosi`=0, `flash_data`=8'h00, `flash_ready`=0, state=`GAP` with counter 0.
- Reset asserted mid-transaction raises CS and lowers SCK immediately (asynchronously). The partial byte is discarded.
- Random fetch: from the first `GAP` cycle to `flash_ready`=1 takes `CS_GAP` + 40·2·`CLK_DIV` + 1 cycles. With defaults this is 163.
- Sequential fetch: from the address change to `flash_ready`=1 takes 1 + 8·2·`CLK_DIV` cycles. With defaults this is 33.
- After reset release, the first fetch is a random fetch of the `flash_addr` present at the end of `GAP`.
- `flash_ready` falls in the same cycle that `flash_addr` changes.

## Structure
- Shared package `flash_spi_pkg`: state enum, `SPI_READ_CMD` = 8'h03, `FLASH_AW` = 12, `SPI_AW` = 24.
- Sub-module `spi_byte_shifter`:
  - Generates SCK from `CLK_DIV`.
  - Shifts 8 bits out and 8 bits in, MSB first.
  - Handshake: `start` in, `done` pulse out.
- The top-level FSM sequences 1 + 3 + 1 bytes through the shifter.

## Test plan
- Reset, `flash_addr`=12'h000, flash model holds 8'hA5 at 0 → MOSI carries 03 00 00 00; `flash_ready` rises at cycle 163 with `flash_data`=8'hA5.
- Step `flash_addr` 0→1→2 → CS stays low, no command is reissued, each byte is ready 33 cycles after its address change, and data matches the model.
- Jump `flash_addr` 12'h002→12'h100 with `BASE_ADDR`=24'h010000 → CS high for ≥2 cycles, then address bytes 01 01 00 are sent and the correct byte is returned.
- Address 12'hFFF → 12'h000 → treated as random: CS toggles and the full command is reissued.
- Change `flash_addr` mid-`ADDR` phase → the old byte completes, `flash_ready` stays 0, and the new fetch starts with the correct path.
- Assert `arst_n` low mid-`DATA` → `spi_cs_n`=1 and `spi_sck`=0 immediately, `flash_ready`=0, `flash_data`=8'h00.
